cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single CDB/writeback port among N_REQ functional units (ALU, MULT, LOAD, BRANCH).
//  Each FU offers one EX_PACKET per valid/ready handshake; one winner per cycle, round-robin.
//  Winner is registered into cdb_packet and drives regfile writeback.
//  Sits between the FU outputs and the RS/ROB/regfile consumers of the CDB.
// PARAMETERS
//  N_REQ   4   number of requesting FUs (>=2); index 0 = highest priority after reset
//  PTR_W   $clog2(N_REQ)  width of round-robin pointer (derived, do not override)
// PORTS
//  clock           in   1          clock; all state updates on posedge
//  reset           in   1          synchronous, active-high
//  squash          in   1          mispredict flush: kill pending and in-flight results
//  req_valid       in   N_REQ      FU i has a result to broadcast
//  req_packet      in   N_REQ x EX_PACKET   result payload per FU
//  req_ready       out  N_REQ      one-hot or zero; FU i's packet accepted this cycle
//  cdb_packet      out  CDB_PACKET registered broadcast (valid, Tag, Value, PC, NPC, dest_reg_idx, take_branch)
//  wb_regfile_en   out  1          cdb_packet.valid && dest_reg_idx != `ZERO_REG
//  wb_regfile_idx  out  5          cdb_packet.dest_reg_idx
//  wb_regfile_data out  `XLEN      cdb_packet.Value
// BEHAVIOUR
//  Reset: rr_ptr=0; cdb_packet all fields 0 (valid=0); req_ready=0; wb_regfile_en=0.
//  Handshake: transfer on req_valid[i] && req_ready[i]. FU holds valid and payload stable until
//   accepted; req_ready is combinational from req_valid, rr_ptr, squash (no dependency on ready).
//  Grant: first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... mod N_REQ. At most one bit
//   of req_ready set. No req_valid -> req_ready=0.
//  Pointer: on transfer from i, rr_ptr <= (i+1) mod N_REQ (wraps N_REQ-1 -> 0); else unchanged.
//  Latency: 1 cycle. Packet accepted in cycle t appears with cdb_packet.valid=1 in t+1, for
//   exactly one cycle unless another transfer occurs in t+1 (back-to-back allowed, 1/cycle).
//  Value = take_branch ? NPC : alu_result (link value); take_branch/Tag/PC/NPC/dest copied;
//   halt, illegal, done driven 0.
//  No transfer in t -> cdb_packet.valid=0 in t+1 (other fields don't-care, keep last value).
//  squash=1 in t: req_ready=0 in t (nothing accepted), cdb_packet.valid=0 in t+1, rr_ptr held.
//   A packet registered in t (on CDB during t) is still visible in t; consumers handle ordering.
//  reset has priority over squash; reset mid-stream drops all pending and in-flight results.
//  req_valid with dest_reg_idx==`ZERO_REG still arbitrated and broadcast (Tag must retire);
//   only wb_regfile_en suppressed.
//  Fairness bound: a continuously valid FU is granted within N_REQ cycles of raising valid.
// STRUCTURE
//  sys_defs.svh: EX_PACKET, CDB_PACKET (existing); add `CDB_N_REQ and FU index enum
//   (FU_ALU=0, FU_MULT=1, FU_LOAD=2, FU_BR=3).
//  Sub-module rr_arbiter #(N) : req[N], ptr -> one-hot gnt[N], gnt_idx; pure combinational
//   (double-width rotate + priority encode). cdb_arbiter owns rr_ptr, output reg, squash gating.
// TESTING
//  1 Single req: req_valid=4'b0100 at t, ALU result 0x1234, dest=5 -> req_ready=0100 at t;
//    t+1 cdb valid, Value=0x1234, wb_en=1, idx=5; rr_ptr=3.
//  2 All four valid continuously from reset -> grants 0,1,2,3,0 on cycles t..t+4; CDB valid
//    every cycle t+1..t+5 with matching Tags.
//  3 Wrap: rr_ptr=3, req_valid=4'b1001 -> grant FU3, then FU0; rr_ptr ends at 1.
//  4 Squash at t with req_valid=4'b1111 -> req_ready=0 at t, cdb valid=0 at t+1, rr_ptr unchanged;
//    t+1 squash=0 -> grant resumes from same rr_ptr.
//  5 take_branch=1, NPC=0x104, alu_result=0x200, dest=1 -> Value=0x104, take_branch=1;
//    dest=`ZERO_REG variant -> cdb valid=1, wb_regfile_en=0.
//  6 Reset asserted mid-burst -> next cycle cdb valid=0, req_ready=0, rr_ptr=0; assert one-hot
//    req_ready and no held-valid FU waits > N_REQ cycles throughout random run.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the CDB writeback arbiter.
package cdb_arbiter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned CDB_N_REQ = 4;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

  // Requester index assignment on the CDB arbiter
  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_LOAD = 2'd2,
    FU_BR   = 2'd3
  } fu_idx_t;

  // Result offered by a functional unit
  typedef struct packed {
    logic [TAG_W-1:0]     Tag;
    logic [XLEN-1:0]      PC;
    logic [XLEN-1:0]      NPC;
    logic [XLEN-1:0]      alu_result;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic                 take_branch;
  } EX_PACKET;

  // Registered broadcast seen by RS/ROB/regfile
  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     Tag;
    logic [XLEN-1:0]      Value;
    logic [XLEN-1:0]      PC;
    logic [XLEN-1:0]      NPC;
    logic [REG_IDX_W-1:0] dest_reg_idx;
    logic                 take_branch;
    logic                 halt;
    logic                 illegal;
    logic                 done;
  } CDB_PACKET;

  // Branches broadcast the link value (NPC) instead of the ALU result
  function automatic CDB_PACKET ex_to_cdb(input EX_PACKET p);
    CDB_PACKET c;
    c              = '0;
    c.valid        = 1'b1;
    c.Tag          = p.Tag;
    c.Value        = p.take_branch ? p.NPC : p.alu_result;
    c.PC           = p.PC;
    c.NPC          = p.NPC;
    c.dest_reg_idx = p.dest_reg_idx;
    c.take_branch  = p.take_branch;
    return c;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PTR_W-1:0] off;
  logic [PTR_W:0]   sum;
  logic             found;

  // Rotate so ptr lands at bit 0, priority-encode, then rotate the index back
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        off   = PTR_W'(j);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(N)) begin
      sum = sum - (PTR_W+1)'(N);
    end
    gnt_idx = sum[PTR_W-1:0];
    gnt     = found ? (N'(1) << gnt_idx) : '0;
    any     = found;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbitration of functional-unit results onto the single CDB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = CDB_N_REQ
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [N_REQ-1:0]           req_valid,
  input  EX_PACKET [N_REQ-1:0]       req_packet,
  output logic [N_REQ-1:0]           req_ready,
  output CDB_PACKET                  cdb_packet,
  output logic                       wb_regfile_en,
  output logic [REG_IDX_W-1:0]       wb_regfile_idx,
  output logic [XLEN-1:0]            wb_regfile_data
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             transfer;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Flush and reset block acceptance so no result is taken that would be dropped
  always_comb begin
    req_ready = (reset || squash) ? '0 : gnt;
    transfer  = gnt_any && !reset && !squash;
    next_ptr  = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Register the winning packet and advance the pointer past the winner
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr     <= '0;
      cdb_packet <= '0;
    end else begin
      cdb_packet.valid <= transfer;
      if (transfer) begin
        rr_ptr     <= next_ptr;
        cdb_packet <= ex_to_cdb(req_packet[gnt_idx]);
      end
    end
  end

  // Writes to the zero register still broadcast so the tag retires
  always_comb begin
    wb_regfile_en   = cdb_packet.valid && (cdb_packet.dest_reg_idx != ZERO_REG);
    wb_regfile_idx  = cdb_packet.dest_reg_idx;
    wb_regfile_data = cdb_packet.Value;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized scoreboard bench for cdb_arbiter.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 squash;
  logic [3:0]           req_valid;
  EX_PACKET [3:0]       req_packet;
  logic [3:0]           req_ready;
  CDB_PACKET            cdb_packet;
  logic                 wb_regfile_en;
  logic [4:0]           wb_regfile_idx;
  logic [XLEN-1:0]      wb_regfile_data;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  typedef struct {
    CDB_PACKET pkt;
    bit        full;
  } exp_t;
  exp_t sb[$];

  cdb_arbiter #(.N_REQ(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .squash          (squash),
    .req_valid       (req_valid),
    .req_packet      (req_packet),
    .req_ready       (req_ready),
    .cdb_packet      (cdb_packet),
    .wb_regfile_en   (wb_regfile_en),
    .wb_regfile_idx  (wb_regfile_idx),
    .wb_regfile_data (wb_regfile_data)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic EX_PACKET mk_ex(input logic [4:0] tag, input logic [31:0] alu,
                                     input logic [31:0] npc, input logic [4:0] dest,
                                     input logic tb);
    EX_PACKET p;
    p.Tag          = tag;
    p.alu_result   = alu;
    p.NPC          = npc;
    p.PC           = npc - 32'd4;
    p.dest_reg_idx = dest;
    p.take_branch  = tb;
    return p;
  endfunction

  function automatic CDB_PACKET mk_cdb(input EX_PACKET p);
    CDB_PACKET c;
    c              = '0;
    c.valid        = 1'b1;
    c.Tag          = p.Tag;
    c.Value        = p.take_branch ? p.NPC : p.alu_result;
    c.PC           = p.PC;
    c.NPC          = p.NPC;
    c.dest_reg_idx = p.dest_reg_idx;
    c.take_branch  = p.take_branch;
    return c;
  endfunction

  function automatic logic [3:0] model_grant(input logic [3:0] v, input int p, input bit blk);
    if (blk) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
    end
    return 4'b0000;
  endfunction

  // One clock: check ready before the edge, push the expected CDB, compare after the edge
  task automatic tick(input logic [3:0] exp_ready);
    exp_t e;
    int   gi;
    #1;
    check("req_ready", req_ready, exp_ready);
    check("ready_onehot", $onehot0(req_ready), 1);
    e.full = reset;
    e.pkt  = '0;
    gi     = -1;
    for (int i = 0; i < 4; i++) if (exp_ready[i]) gi = i;
    if (!reset && gi >= 0) begin
      e.pkt = mk_cdb(req_packet[gi]);
      m_ptr = (gi + 1) % 4;
    end
    if (reset) m_ptr = 0;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("cdb_valid", cdb_packet.valid, e.pkt.valid);
    if (e.full || e.pkt.valid) check("cdb_packet", cdb_packet, e.pkt);
    check("wb_en", wb_regfile_en, e.pkt.valid && (e.pkt.dest_reg_idx != ZERO_REG));
    if (e.pkt.valid) begin
      check("wb_idx", wb_regfile_idx, e.pkt.dest_reg_idx);
      check("wb_data", wb_regfile_data, e.pkt.Value);
    end
    check("rr_ptr", dut.rr_ptr, m_ptr);
  endtask

  initial begin
    logic [3:0] g;
    int         wait_cnt [4];

    reset      = 1'b1;
    squash     = 1'b0;
    req_valid  = 4'b0000;
    req_packet = '0;
    tick(4'b0000);
    tick(4'b0000);
    reset = 1'b0;
    check("reset_ptr", dut.rr_ptr, 0);

    // Single request from FU_LOAD
    req_packet[FU_LOAD] = mk_ex(5'h12, 32'h1234, 32'h48, 5'd5, 1'b0);
    req_valid = 4'b0100;
    tick(4'b0100);
    check("t1_ptr", dut.rr_ptr, 3);
    check("t1_value", wb_regfile_data, 32'h1234);
    req_valid = 4'b0000;
    tick(4'b0000);

    // Wrap from FU_BR back to FU_ALU
    req_packet[FU_BR]  = mk_ex(5'h03, 32'hAAAA, 32'h80, 5'd7, 1'b0);
    req_packet[FU_ALU] = mk_ex(5'h04, 32'hBBBB, 32'h84, 5'd8, 1'b0);
    req_valid = 4'b1001;
    tick(4'b1000);
    req_valid = 4'b0001;
    tick(4'b0001);
    check("t3_ptr", dut.rr_ptr, 1);
    req_valid = 4'b0000;

    // All four held valid from reset
    reset = 1'b1;
    tick(4'b0000);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      req_packet[i] = mk_ex(5'(i + 1), 32'h100 + 32'(i), 32'h200 + 32'(4 * i), 5'(i + 10), 1'b0);
    req_valid = 4'b1111;
    tick(4'b0001);
    req_packet[0] = mk_ex(5'd5, 32'h500, 32'h300, 5'd20, 1'b0);
    tick(4'b0010);
    req_packet[1] = mk_ex(5'd6, 32'h600, 32'h304, 5'd21, 1'b0);
    tick(4'b0100);
    req_packet[2] = mk_ex(5'd7, 32'h700, 32'h308, 5'd22, 1'b0);
    tick(4'b1000);
    req_packet[3] = mk_ex(5'd8, 32'h800, 32'h30C, 5'd23, 1'b0);
    tick(4'b0001);
    check("t2_tag", cdb_packet.Tag, 5'd5);

    // Squash with everything valid: nothing accepted, pointer held
    squash = 1'b1;
    tick(4'b0000);
    check("t4_ptr", dut.rr_ptr, 1);
    squash = 1'b0;
    tick(4'b0010);
    req_valid = 4'b0000;

    // Branch link value, then a zero-register destination
    reset = 1'b1;
    tick(4'b0000);
    reset = 1'b0;
    req_packet[FU_BR] = mk_ex(5'h09, 32'h200, 32'h104, 5'd1, 1'b1);
    req_valid = 4'b1000;
    tick(4'b1000);
    check("t5_value", cdb_packet.Value, 32'h104);
    check("t5_tb", cdb_packet.take_branch, 1'b1);
    req_packet[FU_ALU] = mk_ex(5'h0A, 32'h55, 32'h108, ZERO_REG, 1'b0);
    req_valid = 4'b0001;
    tick(4'b0001);
    check("t5_zero_valid", cdb_packet.valid, 1'b1);
    check("t5_zero_wben", wb_regfile_en, 1'b0);
    req_valid = 4'b0000;

    // Randomized run with a mid-burst reset and occasional squashes
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          req_valid[i]  = 1'b1;
          req_packet[i] = mk_ex(5'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
          wait_cnt[i]   = 0;
        end
      end
      squash = ($urandom_range(0, 9) == 0);
      reset  = (cyc == 150);
      g = model_grant(req_valid, m_ptr, reset || squash);
      tick(g);
      if (reset || squash) begin
        req_valid = 4'b0000;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        if (reset) check("t6_reset_ptr", dut.rr_ptr, 0);
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (req_valid[i]) begin
            if (g[i]) begin
              req_valid[i] = 1'b0;
              wait_cnt[i]  = 0;
            end else begin
              wait_cnt[i]++;
              check("fairness", wait_cnt[i] <= 3, 1'b1);
            end
          end
        end
      end
    end
    reset  = 1'b0;
    squash = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
